// File: rtl/instr_loader.sv
// instr_loader
// Receives a program over a byte stream and writes it into the processor's
// instruction memory, holding the processor in reset until the whole program
// is in place.
//
// Stream format: a 16-bit little-endian word count N, then N words of four
// bytes each, also little-endian.
//
// Ports
//   clk            clock, all state changes on its rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle pulse that restarts a load from the header
//   rx_data        program byte from the byte source
//   rx_valid       rx_data holds a valid byte
//   rx_ready       loader accepts a byte this cycle (independent of rx_valid)
//   instr_in       assembled word to instruction memory (0 outside WRITE)
//   instr_wr_addr  byte address of the write, multiple of 4 (0 outside WRITE)
//   instr_wr_en    instruction memory write strobe
//   proc_reset     active-high processor reset, released only in DONE
//   load_done      program loaded and processor released
//   load_err       header word count exceeded SIZE
//
// state | meaning
// ------+--------------------------------------------------------------
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte
// DATA  | collecting the four bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | program loaded, processor released, bytes ignored
// ERR   | word count too large, processor held, bytes ignored
module instr_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 128,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [WIDTH-1:0]     instr_in,
    output logic [LOGSIZE+1:0]   instr_wr_addr,
    output logic                 instr_wr_en,
    output logic                 proc_reset,
    output logic                 load_done,
    output logic                 load_err
);

    localparam logic [2:0] HDR0  = 3'd0;
    localparam logic [2:0] HDR1  = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    localparam logic [15:0] SIZE_W = 16'(SIZE);

    logic [2:0]         state;
    logic [15:0]        count;
    logic [1:0]         byte_idx;
    logic [LOGSIZE:0]   word_idx;
    logic [WIDTH-1:0]   word_buf;

    logic [15:0]        hdr_count;
    logic [LOGSIZE:0]   word_idx_nxt;
    logic               xfer;

    assign hdr_count    = {rx_data, count[7:0]};
    assign word_idx_nxt = word_idx + 1'b1;
    assign xfer         = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HDR0;
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            word_buf <= '0;
        end else if (start) begin
            state    <= HDR0;
            count    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            word_buf <= '0;
        end else begin
            case (state)
                HDR0: begin
                    if (xfer) begin
                        count[7:0] <= rx_data;
                        state      <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        count[15:8] <= rx_data;
                        byte_idx    <= '0;
                        word_idx    <= '0;
                        if (hdr_count == 16'd0)
                            state <= DONE;
                        else if (hdr_count > SIZE_W)
                            state <= ERR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word_buf[8*byte_idx +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3)
                            state <= WRITE;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx_nxt;
                    // Word index is one bit wider than the address so that
                    // N == SIZE terminates without wrapping back to zero.
                    if ({{(15-LOGSIZE){1'b0}}, word_idx_nxt} == count)
                        state <= DONE;
                    else
                        state <= DATA;
                end
                DONE:    state <= DONE;
                ERR:     state <= ERR;
                default: state <= HDR0;
            endcase
        end
    end

    always_comb begin
        rx_ready      = 1'b0;
        instr_in      = '0;
        instr_wr_addr = '0;
        instr_wr_en   = 1'b0;
        proc_reset    = 1'b1;
        load_done     = 1'b0;
        load_err      = 1'b0;
        case (state)
            HDR0, HDR1, DATA: rx_ready = 1'b1;
            WRITE: begin
                // A restart landing on the write cycle must not reach memory.
                instr_wr_en   = !start;
                instr_in      = word_buf;
                instr_wr_addr = {word_idx[LOGSIZE-1:0], 2'b00};
            end
            DONE: begin
                proc_reset = 1'b0;
                load_done  = 1'b1;
            end
            ERR:     load_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: header handling, word assembly, write
// strobes, flow-control gaps, restart, mid-load reset and full-depth load.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] instr_in;
    logic [8:0]  instr_wr_addr;
    logic        instr_wr_en;
    logic        proc_reset;
    logic        load_done;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    int          wr_cnt = 0;
    int          acc    = 0;
    logic [31:0] wd [0:255];
    logic [8:0]  wa [0:255];

    instr_loader #(.WIDTH(32), .SIZE(128)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .instr_in      (instr_in),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_en   (instr_wr_en),
        .proc_reset    (proc_reset),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    // Record writes and accepted bytes mid-way through the low phase,
    // after the bench has driven its inputs for the cycle.
    always @(negedge clk) begin
        #2;
        if (reset && instr_wr_en) begin
            if (wr_cnt < 256) begin
                wd[wr_cnt] = instr_in;
                wa[wr_cnt] = instr_wr_addr;
            end
            wr_cnt++;
        end
        if (reset && rx_valid && rx_ready)
            acc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wr_cnt = 0;
        acc    = 0;
    endtask

    // Called at a negedge; leaves rx_valid high so consecutive calls stream
    // one byte per cycle. Waits out cycles where rx_ready is low.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rx_ready stayed low for byte %h", b);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        rx_valid = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulse_start();
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr();
    endtask

    logic [7:0] v034 [0:5];
    logic [7:0] bb;
    int         bad;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        v034[0] = 8'h01; v034[1] = 8'h00; v034[2] = 8'hB7;
        v034[3] = 8'h04; v034[4] = 8'h00; v034[5] = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_rx_ready",   32'(rx_ready),      32'd1);
        chk("rst_proc_reset", 32'(proc_reset),    32'd1);
        chk("rst_wr_en",      32'(instr_wr_en),   32'd0);
        chk("rst_instr_in",   instr_in,           32'd0);
        chk("rst_wr_addr",    32'(instr_wr_addr), 32'd0);
        chk("rst_load_done",  32'(load_done),     32'd0);
        chk("rst_load_err",   32'(load_err),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clr();

        // Two-word program.
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        idle(4);
        chk("two_wr_count",   32'(wr_cnt),     32'd2);
        chk("two_wd0",        wd[0],           32'h0000_0013);
        chk("two_wa0",        32'(wa[0]),      32'd0);
        chk("two_wd1",        wd[1],           32'h0010_0093);
        chk("two_wa1",        32'(wa[1]),      32'd4);
        chk("two_load_done",  32'(load_done),  32'd1);
        chk("two_proc_reset", 32'(proc_reset), 32'd0);
        chk("two_rx_ready",   32'(rx_ready),   32'd0);
        chk("two_accepted",   32'(acc),        32'd10);

        // Empty program.
        pulse_start();
        #1;
        chk("start_rx_ready",  32'(rx_ready),   32'd1);
        chk("start_load_done", 32'(load_done),  32'd0);
        chk("start_proc_rst",  32'(proc_reset), 32'd1);
        send_byte(8'h00);
        chk("empty_after_b0", 32'(load_done), 32'd0);
        send_byte(8'h00);
        chk("empty_done",     32'(load_done), 32'd1);
        idle(3);
        chk("empty_wr_count", 32'(wr_cnt),    32'd0);

        // Oversized header.
        pulse_start();
        send_byte(8'h81); send_byte(8'h00);
        #1;
        chk("err_load_err",   32'(load_err),   32'd1);
        chk("err_proc_reset", 32'(proc_reset), 32'd1);
        chk("err_rx_ready",   32'(rx_ready),   32'd0);
        chk("err_load_done",  32'(load_done),  32'd0);
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(8'h40 + i);
            @(negedge clk);
        end
        idle(3);
        chk("err_wr_count",   32'(wr_cnt),     32'd0);
        chk("err_accepted",   32'(acc),        32'd2);
        chk("err_still_err",  32'(load_err),   32'd1);

        // One-word load with valid pattern 1-0-0 per byte.
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1;
            rx_data  = v034[i];
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (2) @(negedge clk);
            if (i == 3) begin
                chk("gap_no_early_wr", 32'(wr_cnt),    32'd0);
                chk("gap_rx_ready",    32'(rx_ready),  32'd1);
            end
        end
        idle(3);
        chk("gap_wr_count",  32'(wr_cnt),    32'd1);
        chk("gap_wd0",       wd[0],          32'h0000_04B7);
        chk("gap_wa0",       32'(wa[0]),     32'd0);
        chk("gap_accepted",  32'(acc),       32'd6);
        chk("gap_load_done", 32'(load_done), 32'd1);

        // Restart after two bytes of word 1, then a fresh one-word load.
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        pulse_start();
        #1;
        chk("rst1_rx_ready",  32'(rx_ready),   32'd1);
        chk("rst1_proc_rst",  32'(proc_reset), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        chk("rst1_wr_count",  32'(wr_cnt),    32'd1);
        chk("rst1_wd0",       wd[0],          32'hDDCC_BBAA);
        chk("rst1_wa0",       32'(wa[0]),     32'd0);
        chk("rst1_load_done", 32'(load_done), 32'd1);

        // Start arriving exactly in the WRITE cycle suppresses the write.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        rx_valid = 1'b0;
        start    = 1'b1;
        #1;
        chk("startwr_wr_en",  32'(instr_wr_en), 32'd0);
        @(negedge clk);
        start = 1'b0;
        idle(3);
        chk("startwr_count",  32'(wr_cnt),    32'd0);
        chk("startwr_hdr0",   32'(rx_ready),  32'd1);
        chk("startwr_done",   32'(load_done), 32'd0);

        // Reset asserted mid-load, then a new load from the header.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h77); send_byte(8'h88);
        rx_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("mrst_rx_ready", 32'(rx_ready),    32'd1);
        chk("mrst_proc_rst", 32'(proc_reset),  32'd1);
        chk("mrst_wr_en",    32'(instr_wr_en), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clr();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle(3);
        chk("mrst_wr_count", 32'(wr_cnt), 32'd1);
        chk("mrst_wd0",      wd[0],       32'h0403_0201);
        chk("mrst_wa0",      32'(wa[0]),  32'd0);

        // Full-depth load.
        pulse_start();
        send_byte(8'h80); send_byte(8'h00);
        for (int i = 0; i < 128; i++) begin
            for (int k = 0; k < 4; k++) begin
                bb = (k == 0) ? 8'(i) : 8'(8'hA0 + k);
                send_byte(bb);
            end
        end
        idle(4);
        chk("full_wr_count", 32'(wr_cnt), 32'd128);
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (wa[i] !== 9'(4 * i) || wd[i] !== {8'hA3, 8'hA2, 8'hA1, 8'(i)})
                bad++;
        end
        chk("full_entries",   32'(bad),        32'd0);
        chk("full_last_addr", 32'(wa[127]),    32'h1FC);
        chk("full_last_data", wd[127],         32'hA3A2_A17F);
        chk("full_load_done", 32'(load_done),  32'd1);
        chk("full_proc_rst",  32'(proc_reset), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: WIDTH, 32, instruction word width in bits (fixed 32; four bytes per word).
REQ-002 Parameter: SIZE, 128, instruction memory depth in words; LOGSIZE = $clog2(SIZE).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
REQ-005 start  input  1  one-cycle pulse that restarts a program load.
REQ-006 rx_data  input  8  program byte from the byte source.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  the loader accepts a byte this cycle.
REQ-009 instr_in  output  WIDTH  assembled instruction word to the processor instruction memory.
REQ-010 instr_wr_addr  output  LOGSIZE+2  byte address of the write, always a multiple of 4.
REQ-011 instr_wr_en  output  1  instruction memory write strobe.
REQ-012 proc_reset  output  1  active-high reset held on the processor while loading.
REQ-013 load_done  output  1  program loaded and processor released.
REQ-014 load_err  output  1  header word count exceeds SIZE.

Function
REQ-015 A byte transfer occurs on a posedge where rx_valid=1 and rx_ready=1; rx_ready does not depend combinationally on rx_valid.
REQ-016 States: HDR0, HDR1, DATA, WRITE, DONE, ERR.
REQ-017 HDR0 and HDR1: rx_ready=1; HDR0 captures count[7:0]; HDR1 captures count[15:8], so N is a 16-bit little-endian word count.
REQ-018 After HDR1 transfer: N=0 -> DONE; N>SIZE -> ERR; otherwise -> DATA with byte index 0, word index 0.
REQ-019 DATA: rx_ready=1; each transfer writes byte k (k=0..3) into word bits [8k+7:8k] (little-endian); the 4th transfer -> WRITE.
REQ-020 WRITE: exactly one cycle; instr_wr_en=1, instr_in=assembled word, instr_wr_addr=4*word index, rx_ready=0.
REQ-021 Leaving WRITE: word index increments; when the new index equals N -> DONE, else -> DATA.
REQ-022 instr_wr_en=0 in every state except WRITE; instr_in and instr_wr_addr are 0 outside WRITE.
REQ-023 proc_reset=1 in every state except DONE; in DONE, proc_reset=0 and load_done=1.
REQ-024 ERR: load_err=1, proc_reset=1, rx_ready=0; incoming bytes are ignored.
REQ-025 DONE: rx_ready=0; incoming bytes are ignored.
REQ-026 start=1 in any state -> HDR0 on the next edge, discarding the partial word, counters and flags. This overrides all other transitions, including WRITE (no write is issued that edge).
REQ-027 rx_valid gaps of any length in HDR0, HDR1 or DATA stall the FSM with no state or data change.
REQ-028 Word index counter is LOGSIZE+1 bits wide; N=SIZE loads addresses 0..4*(SIZE-1) without wrap.

Reset
REQ-029 While reset=0: state=HDR0, rx_ready=1, proc_reset=1, instr_wr_en=0, instr_in=0, instr_wr_addr=0, load_done=0, load_err=0, all counters 0.
REQ-030 A reset asserted mid-load aborts the load with no further write strobe; after release the loader expects a new header.

Verification
REQ-031 Header 02 00, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013@0, then 0x00100093@4, each a single cycle; load_done=1, proc_reset=0.
REQ-032 Header 00 00 -> DONE two edges after the first header byte; no write strobe.
REQ-033 Header 81 00 (N=129, SIZE=128) -> load_err=1, proc_reset stays 1; following bytes produce no writes.
REQ-034 rx_valid toggled 1-0-0-1 per byte during a 1-word load -> same single write as the continuous case; total accepted bytes = 6.
REQ-035 start pulsed after 2 data bytes of word 1 -> back to HDR0; a new header 01 00 plus 4 bytes writes @0 only.
REQ-036 N=128 with continuous bytes -> 128 writes, last at address 0x1FC; then DONE.
